ethernet_udp_receive: RTL and testbench

- Receive-side counterpart of the UDP transmit path.
- Consumes MII receive nibbles, already synchronous to clk and qualified by a nibble strobe. Finds preamble/SFD and assembles bytes.
- Filters on MAC/IPv4/UDP headers addressed to this node and streams the UDP payload out one byte at a time.
- Reports sender addressing plus a per-frame good/bad verdict from the FCS check.

---
 rtl/ethernet_udp_receive_pkg.sv | 53 +++++
 rtl/ethernet_udp_receive_crc32_byte.sv | 32 +++
 rtl/ethernet_udp_receive.sv | 216 +++++++++++++++++++++
 tb/tb_ethernet_udp_receive.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ethernet_udp_receive_pkg.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
//  Module   : ethernet_udp_receive_pkg
//  Purpose  : Shared constants, header offsets and rx state encoding for the
//             UDP receive path (CRC constants shared with the transmit side).
//  Revision : 1.0  initial release
// ============================================================================
package ethernet_udp_receive_pkg;

    localparam logic [15:0] ETHERTYPE_IPV4  = 16'h0800;
    localparam logic [7:0]  IP_PROTO_UDP    = 8'h11;
    localparam logic [7:0]  IPV4_VER_IHL    = 8'h45;
    localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB88320;
    localparam logic [31:0] CRC32_RESIDUE   = 32'hDEBB20E3;
    localparam logic [31:0] CRC32_INIT      = 32'hFFFFFFFF;

    // Byte offsets from the first destination-MAC byte
    localparam logic [15:0] HDR_DST_MAC   = 16'd0;
    localparam logic [15:0] HDR_SRC_MAC   = 16'd6;
    localparam logic [15:0] HDR_ETHERTYPE = 16'd12;
    localparam logic [15:0] HDR_VER_IHL   = 16'd14;
    localparam logic [15:0] HDR_PROTO     = 16'd23;
    localparam logic [15:0] HDR_SRC_IP    = 16'd26;
    localparam logic [15:0] HDR_DST_IP    = 16'd30;
    localparam logic [15:0] HDR_SRC_PORT  = 16'd34;
    localparam logic [15:0] HDR_DST_PORT  = 16'd36;
    localparam logic [15:0] HDR_UDP_LEN   = 16'd38;
    localparam logic [15:0] HDR_LAST      = 16'd41;

    localparam logic [15:0] MIN_FRAME_BYTES = 16'd64;
    localparam logic [15:0] UDP_HDR_BYTES   = 16'd8;

    // Receive state encoding
    typedef logic [2:0] rx_state_t;
    localparam rx_state_t ST_WAIT_IDLE = 3'd0;
    localparam rx_state_t ST_IDLE      = 3'd1;
    localparam rx_state_t ST_PREAMBLE  = 3'd2;
    localparam rx_state_t ST_HEADER    = 3'd3;
    localparam rx_state_t ST_PAYLOAD   = 3'd4;
    localparam rx_state_t ST_TRAILER   = 3'd5;
    localparam rx_state_t ST_DROP      = 3'd6;

    // Byte idx (0 = most significant) of a left-aligned 48-bit field
    function automatic logic [7:0] field_byte(input logic [47:0] field,
                                              input logic [15:0] idx);
        logic [47:0] shifted;
        shifted = field << {idx, 3'b000};
        return shifted[47:40];
    endfunction

endpackage
`default_nettype wire

// File: rtl/ethernet_udp_receive_crc32_byte.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
//  Module   : crc32_byte
//  Purpose  : Combinational next-state of the reflected Ethernet CRC32 for
//             one data byte (LSB first). Shared by rx and tx paths.
//  Revision : 1.0  initial release
// ============================================================================
module crc32_byte
    import ethernet_udp_receive_pkg::*;
(
    input  logic [31:0] i_crc,
    input  logic [7:0]  i_data,
    output logic [31:0] o_crc
);

    logic [31:0] w_crc;

    // Eight serial LFSR steps, data bit 0 first
    always_comb begin
        w_crc = i_crc;
        for (int i = 0; i < 8; i++) begin
            if (w_crc[0] ^ i_data[i])
                w_crc = (w_crc >> 1) ^ CRC32_POLY_REFL;
            else
                w_crc = w_crc >> 1;
        end
        o_crc = w_crc;
    end

endmodule
`default_nettype wire

// File: rtl/ethernet_udp_receive.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
//  Module   : ethernet_udp_receive
//  Purpose  : MII nibble receiver: preamble/SFD hunt, MAC/IPv4/UDP header
//             filter, payload byte stream and FCS-based frame verdict.
//  Revision : 1.0  initial release
// ============================================================================
module ethernet_udp_receive
    import ethernet_udp_receive_pkg::*;
#(
    parameter int unsigned MAX_PAYLOAD      = 1472,
    parameter int unsigned ACCEPT_BROADCAST = 1
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        rx_stb,
    input  logic        rx_dv,
    input  logic [3:0]  rx_d,
    input  logic [47:0] local_mac,
    input  logic [31:0] local_ip,
    input  logic [15:0] local_port,
    output logic [7:0]  data,
    output logic        valid,
    output logic        frame_done,
    output logic        frame_ok,
    output logic [47:0] src_mac,
    output logic [31:0] src_ip,
    output logic [15:0] src_port,
    output logic [15:0] payload_len,
    output logic        busy
);

    localparam logic [15:0] c_max_udp_len  = 16'(MAX_PAYLOAD + 8);
    localparam bit          c_accept_bcast = (ACCEPT_BROADCAST != 0);

    rx_state_t   r_state, w_next_state;
    logic [3:0]  r_low_nib;
    logic        r_nib_odd;       // low nibble of the current byte is held
    logic [15:0] r_byte_cnt;
    logic [31:0] r_crc;
    logic        r_mac_ok, r_bc_ok;
    logic [7:0]  r_len_hi;
    logic [15:0] r_pay_left;
    logic [2:0]  r_trail_cnt;     // trailer bytes, saturating at 4

    logic        w_in_frame, w_byte_done, w_sfd;
    logic [7:0]  w_byte;
    logic [31:0] w_crc_next;
    logic        w_mac_ok_next, w_bc_ok_next, w_hdr_bad;
    logic [15:0] w_udp_len;
    logic        w_frame_end, w_frame_ok;

    assign w_byte      = {rx_d, r_low_nib};
    assign w_in_frame  = (r_state == ST_HEADER) || (r_state == ST_PAYLOAD) ||
                         (r_state == ST_TRAILER);
    assign w_byte_done = rx_stb && rx_dv && r_nib_odd && w_in_frame;
    assign w_sfd       = (r_state == ST_PREAMBLE) && (w_next_state == ST_HEADER);

    crc32_byte u_crc (
        .i_crc  (r_crc),
        .i_data (w_byte),
        .o_crc  (w_crc_next)
    );

    // Header field checks for the byte completing this strobe
    always_comb begin
        w_mac_ok_next = r_mac_ok && (w_byte == field_byte(local_mac, r_byte_cnt));
        w_bc_ok_next  = r_bc_ok && (w_byte == 8'hFF);
        w_udp_len     = {r_len_hi, w_byte};
        w_hdr_bad     = 1'b0;
        if (r_byte_cnt < HDR_SRC_MAC)
            w_hdr_bad = !(w_mac_ok_next || (c_accept_bcast && w_bc_ok_next));
        else if (r_byte_cnt == HDR_ETHERTYPE)
            w_hdr_bad = (w_byte != ETHERTYPE_IPV4[15:8]);
        else if (r_byte_cnt == HDR_ETHERTYPE + 16'd1)
            w_hdr_bad = (w_byte != ETHERTYPE_IPV4[7:0]);
        else if (r_byte_cnt == HDR_VER_IHL)
            w_hdr_bad = (w_byte != IPV4_VER_IHL);
        else if (r_byte_cnt == HDR_PROTO)
            w_hdr_bad = (w_byte != IP_PROTO_UDP);
        else if (r_byte_cnt >= HDR_DST_IP && r_byte_cnt < HDR_SRC_PORT)
            w_hdr_bad = (w_byte != field_byte({local_ip, 16'h0000}, r_byte_cnt - HDR_DST_IP));
        else if (r_byte_cnt >= HDR_DST_PORT && r_byte_cnt < HDR_UDP_LEN)
            w_hdr_bad = (w_byte != field_byte({local_port, 32'h0}, r_byte_cnt - HDR_DST_PORT));
        else if (r_byte_cnt == HDR_UDP_LEN + 16'd1)
            w_hdr_bad = (w_udp_len < UDP_HDR_BYTES) || (w_udp_len > c_max_udp_len);
    end

    // Next-state and end-of-frame verdict, advanced only on strobes
    always_comb begin
        w_next_state = r_state;
        w_frame_end  = 1'b0;
        w_frame_ok   = 1'b0;
        if (rx_stb) begin
            case (r_state)
                ST_WAIT_IDLE: if (!rx_dv) w_next_state = ST_IDLE;
                ST_IDLE:      if (rx_dv && rx_d == 4'h5) w_next_state = ST_PREAMBLE;
                ST_PREAMBLE: begin
                    if (!rx_dv)               w_next_state = ST_WAIT_IDLE;
                    else if (rx_d == 4'hD)    w_next_state = ST_HEADER;
                    else if (rx_d != 4'h5)    w_next_state = ST_WAIT_IDLE;
                end
                ST_HEADER: begin
                    if (!rx_dv)
                        w_next_state = ST_IDLE;
                    else if (w_byte_done && w_hdr_bad)
                        w_next_state = ST_DROP;
                    else if (w_byte_done && r_byte_cnt == HDR_LAST)
                        w_next_state = (payload_len == 16'd0) ? ST_TRAILER : ST_PAYLOAD;
                end
                ST_PAYLOAD: begin
                    if (!rx_dv) begin
                        w_next_state = ST_IDLE;
                        w_frame_end  = 1'b1;
                    end else if (w_byte_done && r_pay_left == 16'd1) begin
                        w_next_state = ST_TRAILER;
                    end
                end
                ST_TRAILER: begin
                    if (!rx_dv) begin
                        w_next_state = ST_IDLE;
                        w_frame_end  = 1'b1;
                        w_frame_ok   = (r_crc == CRC32_RESIDUE) &&
                                       (r_byte_cnt >= MIN_FRAME_BYTES) &&
                                       !r_nib_odd && (r_trail_cnt == 3'd4);
                    end
                end
                ST_DROP:  if (!rx_dv) w_next_state = ST_IDLE;
                default:  w_next_state = ST_WAIT_IDLE;
            endcase
        end
    end

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) r_state <= ST_WAIT_IDLE;
        else       r_state <= w_next_state;
    end

    // Byte assembly, CRC, header capture and output registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_low_nib   <= '0;
            r_nib_odd   <= 1'b0;
            r_byte_cnt  <= '0;
            r_crc       <= '0;
            r_mac_ok    <= 1'b0;
            r_bc_ok     <= 1'b0;
            r_len_hi    <= '0;
            r_pay_left  <= '0;
            r_trail_cnt <= '0;
            data        <= '0;
            valid       <= 1'b0;
            frame_done  <= 1'b0;
            frame_ok    <= 1'b0;
            src_mac     <= '0;
            src_ip      <= '0;
            src_port    <= '0;
            payload_len <= '0;
            busy        <= 1'b0;
        end else begin
            valid      <= 1'b0;
            frame_done <= 1'b0;
            busy       <= (w_next_state == ST_HEADER) || (w_next_state == ST_PAYLOAD) ||
                          (w_next_state == ST_TRAILER) || (w_next_state == ST_DROP);
            if (w_frame_end) begin
                frame_done <= 1'b1;
                frame_ok   <= w_frame_ok;
            end
            if (w_sfd) begin
                r_nib_odd   <= 1'b0;
                r_byte_cnt  <= '0;
                r_crc       <= CRC32_INIT;
                r_mac_ok    <= 1'b1;
                r_bc_ok     <= 1'b1;
                r_trail_cnt <= '0;
            end else if (rx_stb && rx_dv && w_in_frame && !r_nib_odd) begin
                r_low_nib <= rx_d;
                r_nib_odd <= 1'b1;
            end else if (w_byte_done) begin
                r_nib_odd <= 1'b0;
                r_crc     <= w_crc_next;
                if (r_byte_cnt != 16'hFFFF)
                    r_byte_cnt <= r_byte_cnt + 16'd1;
                if (r_state == ST_HEADER) begin
                    if (r_byte_cnt < HDR_SRC_MAC) begin
                        r_mac_ok <= w_mac_ok_next;
                        r_bc_ok  <= w_bc_ok_next;
                    end
                    if (r_byte_cnt >= HDR_SRC_MAC && r_byte_cnt < HDR_ETHERTYPE)
                        src_mac <= {src_mac[39:0], w_byte};
                    if (r_byte_cnt >= HDR_SRC_IP && r_byte_cnt < HDR_DST_IP)
                        src_ip <= {src_ip[23:0], w_byte};
                    if (r_byte_cnt >= HDR_SRC_PORT && r_byte_cnt < HDR_DST_PORT)
                        src_port <= {src_port[7:0], w_byte};
                    if (r_byte_cnt == HDR_UDP_LEN)
                        r_len_hi <= w_byte;
                    if (r_byte_cnt == HDR_UDP_LEN + 16'd1 && !w_hdr_bad)
                        payload_len <= w_udp_len - UDP_HDR_BYTES;
                    if (r_byte_cnt == HDR_LAST)
                        r_pay_left <= payload_len;
                end
                if (r_state == ST_PAYLOAD) begin
                    data       <= w_byte;
                    valid      <= 1'b1;
                    r_pay_left <= r_pay_left - 16'd1;
                end
                if (r_state == ST_TRAILER && r_trail_cnt != 3'd4)
                    r_trail_cnt <= r_trail_cnt + 3'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ethernet_udp_receive.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
//  Module   : tb_ethernet_udp_receive
//  Purpose  : Directed self-checking bench for ethernet_udp_receive.
//  Revision : 1.0  initial release
// ============================================================================
module tb_ethernet_udp_receive;

    localparam logic [47:0] LOCAL_MAC  = 48'h02_00_00_00_00_01;
    localparam logic [31:0] LOCAL_IP   = 32'hC0A8_0102;
    localparam logic [15:0] LOCAL_PORT = 16'd5000;
    localparam logic [47:0] PEER_MAC   = 48'h02_11_22_33_44_55;
    localparam logic [31:0] PEER_IP    = 32'hC0A8_0101;
    localparam logic [15:0] PEER_PORT  = 16'h04D2;

    logic        clk = 1'b0;
    logic        rstn, rx_stb, rx_dv;
    logic [3:0]  rx_d;
    logic [7:0]  data;
    logic        valid, frame_done, frame_ok, busy;
    logic [47:0] src_mac;
    logic [31:0] src_ip;
    logic [15:0] src_port, payload_len;

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  frm[$];
    logic [7:0]  got[$];
    int          done_cnt;
    logic        last_ok;
    logic [7:0]  exp_pay [0:3];

    always #5 clk = ~clk;

    ethernet_udp_receive #(
        .MAX_PAYLOAD      (1472),
        .ACCEPT_BROADCAST (1)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .rx_stb      (rx_stb),
        .rx_dv       (rx_dv),
        .rx_d        (rx_d),
        .local_mac   (LOCAL_MAC),
        .local_ip    (LOCAL_IP),
        .local_port  (LOCAL_PORT),
        .data        (data),
        .valid       (valid),
        .frame_done  (frame_done),
        .frame_ok    (frame_ok),
        .src_mac     (src_mac),
        .src_ip      (src_ip),
        .src_port    (src_port),
        .payload_len (payload_len),
        .busy        (busy)
    );

    // Record payload bytes and frame verdicts away from the active edge
    always @(negedge clk) begin
        if (valid) got.push_back(data);
        if (frame_done) begin
            done_cnt = done_cnt + 1;
            last_ok  = frame_ok;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c ^ {24'h0, b};
        for (int k = 0; k < 8; k++)
            r = (r >> 1) ^ (32'hEDB88320 & {32{r[0]}});
        return r;
    endfunction

    task automatic push_be(input logic [47:0] v, input int n);
        for (int i = 0; i < n; i++) frm.push_back(v[8*(n-1-i) +: 8]);
    endtask

    task automatic build_frame(input logic [47:0] dst, input logic [15:0] ulen);
        logic [31:0] c;
        frm.delete();
        push_be(dst, 6);            push_be(PEER_MAC, 6);
        push_be(48'h0800, 2);       push_be(48'h45, 1);   push_be(48'h00, 1);
        push_be(48'h0020, 2);       push_be(48'h0, 4);
        push_be(48'h40, 1);         push_be(48'h11, 1);   push_be(48'h0, 2);
        push_be({16'h0, PEER_IP}, 4); push_be({16'h0, LOCAL_IP}, 4);
        push_be({32'h0, PEER_PORT}, 2); push_be({32'h0, LOCAL_PORT}, 2);
        push_be({32'h0, ulen}, 2);  push_be(48'h0, 2);
        for (int i = 0; i < 4; i++) frm.push_back(exp_pay[i]);
        while (frm.size() < 60) frm.push_back(8'h00);
        c = 32'hFFFFFFFF;
        foreach (frm[i]) c = crc_step(c, frm[i]);
        c = ~c;
        push_be({16'h0, c[7:0], c[15:8], c[23:16], c[31:24]}, 4);
    endtask

    task automatic nib(input logic dv, input logic [3:0] d);
        @(negedge clk);
        rx_stb = 1'b1; rx_dv = dv; rx_d = d;
        @(negedge clk);
        rx_stb = 1'b0;
    endtask

    task automatic send_bytes(input int from, input int upto);
        logic [7:0] b;
        for (int i = from; i < upto; i++) begin
            b = frm[i];
            nib(1'b1, b[3:0]);
            nib(1'b1, b[7:4]);
        end
    endtask

    task automatic send_frame(input int nbytes);
        for (int i = 0; i < 15; i++) nib(1'b1, 4'h5);
        nib(1'b1, 4'hD);
        send_bytes(0, nbytes);
    endtask

    task automatic send_idle(input int n);
        for (int i = 0; i < n; i++) nib(1'b0, 4'h0);
    endtask

    task automatic clear_mon();
        got.delete();
        done_cnt = 0;
        last_ok  = 1'b0;
    endtask

    task automatic check_rx(input string tag, input int nbytes, input int ndone, input logic ok);
        check({tag, "_nbytes"}, 64'(got.size()), 64'(nbytes));
        for (int i = 0; i < nbytes; i++)
            check({tag, "_byte"}, 64'((i < got.size()) ? got[i] : 8'hxx), 64'(exp_pay[i]));
        check({tag, "_done"}, 64'(done_cnt), 64'(ndone));
        if (ndone > 0) check({tag, "_ok"}, 64'(last_ok), 64'(ok));
        check({tag, "_busy_end"}, 64'(busy), 64'(0));
    endtask

    initial begin
        exp_pay[0] = 8'hDE; exp_pay[1] = 8'hAD; exp_pay[2] = 8'hBE; exp_pay[3] = 8'hEF;
        rstn = 1'b0; rx_stb = 1'b0; rx_dv = 1'b0; rx_d = 4'h0;
        clear_mon();
        repeat (3) @(negedge clk);
        check("rst_valid", 64'(valid), 64'(0));
        check("rst_data", 64'(data), 64'(0));
        check("rst_done", 64'(frame_done), 64'(0));
        check("rst_ok", 64'(frame_ok), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_src_mac", 64'(src_mac), 64'(0));
        check("rst_len", 64'(payload_len), 64'(0));
        rstn = 1'b1;
        send_idle(4);

        // Good unicast frame
        build_frame(LOCAL_MAC, 16'd12);
        clear_mon();
        send_frame(frm.size());
        check("good_busy_in", 64'(busy), 64'(1));
        send_idle(24);
        check_rx("good", 4, 1, 1'b1);
        check("good_len", 64'(payload_len), 64'(4));
        check("good_src_mac", 64'(src_mac), 64'(PEER_MAC));
        check("good_src_ip", 64'(src_ip), 64'(PEER_IP));
        check("good_src_port", 64'(src_port), 64'(PEER_PORT));

        // One FCS bit flipped
        frm[frm.size()-1] = frm[frm.size()-1] ^ 8'h01;
        clear_mon();
        send_frame(frm.size());
        send_idle(24);
        check_rx("badfcs", 4, 1, 1'b0);

        // Destination MAC differs in last byte
        build_frame(48'h02_00_00_00_00_02, 16'd12);
        clear_mon();
        send_frame(frm.size());
        check("wrongmac_busy_in", 64'(busy), 64'(1));
        send_idle(24);
        check_rx("wrongmac", 0, 0, 1'b0);

        // Broadcast destination
        build_frame(48'hFFFF_FFFF_FFFF, 16'd12);
        clear_mon();
        send_frame(frm.size());
        send_idle(24);
        check_rx("bcast", 4, 1, 1'b1);

        // UDP length above MAX_PAYLOAD+8, then a good frame after the gap
        build_frame(LOCAL_MAC, 16'd1481);
        clear_mon();
        send_frame(frm.size());
        send_idle(24);
        check_rx("toolong", 0, 0, 1'b0);
        build_frame(LOCAL_MAC, 16'd12);
        send_frame(frm.size());
        send_idle(24);
        check_rx("after_long", 4, 1, 1'b1);

        // UDP length below the header size
        build_frame(LOCAL_MAC, 16'd7);
        clear_mon();
        send_frame(frm.size());
        send_idle(24);
        check_rx("tooshort", 0, 0, 1'b0);

        // Carrier lost after two payload bytes
        build_frame(LOCAL_MAC, 16'd12);
        clear_mon();
        send_frame(44);
        send_idle(24);
        check_rx("trunc", 2, 1, 1'b0);

        // Reset mid-payload
        clear_mon();
        send_frame(44);
        @(negedge clk);
        rstn = 1'b0;
        #1;
        check("midrst_valid", 64'(valid), 64'(0));
        check("midrst_busy", 64'(busy), 64'(0));
        check("midrst_len", 64'(payload_len), 64'(0));
        check("midrst_src_mac", 64'(src_mac), 64'(0));
        check("midrst_src_port", 64'(src_port), 64'(0));
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        clear_mon();
        send_bytes(44, frm.size());
        send_idle(24);
        check_rx("midrst_rest", 0, 0, 1'b0);
        send_frame(frm.size());
        send_idle(24);
        check_rx("midrst_next", 4, 1, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
